hms_clock_ctrl: RTL
===================

Name: hms_clock_ctrl

Overview:
- Time-of-day controller that sequences the hour/minute/second counters feeding the six-digit 7-seg display path (digit split, then decode, then multiplexed display).
- Advances time on an upstream 1 Hz tick pulse.
- Provides a button-driven set mode that edits the seconds, minutes and hours fields.
- Drives per-digit blanking so the field being edited blinks.

Parameters:
- BLINK_HALF, 25000000, clk cycles per blink half-period (0.5 s at 50 MHz); must be ≥2.

Ports:
- clk  input  1  system clock, 50 MHz
- rst  input  1  reset; asynchronous, active-high
- i_tick  input  1  one-clk-wide 1 Hz enable pulse
- i_btn_mode  input  1  debounced level, high while pressed; toggles between run and set
- i_btn_sel  input  1  debounced level; cycles the edited field
- i_btn_inc  input  1  debounced level; increments the edited field
- o_sec  output  6  seconds, 0..59
- o_min  output  6  minutes, 0..59
- o_hour  output  5  hours, 0..23
- o_state  output  2  0 RUN, 1 SET_SEC, 2 SET_MIN, 3 SET_HOUR
- o_blank  output  6  digit blank mask; [1:0] sec, [3:2] min, [5:4] hour; 1 means digit off

Behaviour:
- Reset (async, while rst=1):
  - o_sec=0, o_min=0, o_hour=0, o_state=RUN, o_blank=0.
  - Blink counter=0, blink phase=0.
  - Button history registers=0, so a button already held at reset release produces no press.
- Press detection:
  - A press is a rising edge of the registered button level (prev=0, cur=1).
  - Each press is a one-cycle event. Holding a button produces no repeats.
- Priority within one cycle: mode > sel > inc. Lower-priority presses in the same cycle are discarded.
- FSM:
  - RUN + mode press -> SET_SEC.
  - Any SET_x + mode press -> RUN.
  - Sel press: SET_SEC -> SET_MIN -> SET_HOUR -> SET_SEC. Sel in RUN is ignored.
  - Inc in RUN is ignored.
- RUN counting on i_tick (all outputs update the cycle after the tick):
  - sec+1.
  - sec 59 -> 0 with carry to min.
  - min 59 -> 0 with carry to hour.
  - hour 23 -> 0.
  - 23:59:59 + tick -> 00:00:00.
- SET states:
  - i_tick is ignored; time is frozen.
  - Inc press adds 1 to the selected field only, with no carry: sec/min 59 -> 0, hour 23 -> 0.
- Blink:
  - The counter runs only in SET states. It counts 0..BLINK_HALF-1, then wraps and toggles the phase.
  - Counter and phase clear to 0 on entry to SET_SEC, on every sel press, and on every inc press, so the edited value is visible immediately.
  - o_blank = 2'b11 on the selected field's pair when phase=1, else 0.
  - In RUN, o_blank=0 and the counter is held at 0.
- All outputs are registered, with 1-cycle latency from press or tick.
- Reset mid-set returns to RUN at 00:00:00; the edited values are lost.
- Out-of-range values are unreachable. Any field found out of range is forced to 0 on its next update.

Optional Feature:
- Macro: HMS_CLOCK_CTRL_ALARM_EN.
- Defined:
  - Adds ports i_alarm_on (1), i_alarm_hour (5), i_alarm_min (6), o_alarm (1).
  - o_alarm rises the cycle after a RUN tick produces hour==i_alarm_hour, min==i_alarm_min, sec==0 while i_alarm_on=1.
  - o_alarm stays high for 60 ticks, or until any button press or i_alarm_on=0, whichever comes first.
  - o_alarm is forced low in SET states; reset value 0.
- Undefined: none of these ports or registers exist. The behaviour above is unchanged.

Decomposition:
- Package hms_clock_pkg:
  - State encoding constants ST_RUN, ST_SET_SEC, ST_SET_MIN, ST_SET_HOUR (2-bit).
  - Field limits SEC_MAX=59, MIN_MAX=59, HOUR_MAX=23.
  - Blank masks BLANK_SEC=6'b000011, BLANK_MIN=6'b001100, BLANK_HOUR=6'b110000.
  - Alarm duration ALARM_TICKS=60.
- Sub-module btn_edge (registered rising-edge detector, async active-high reset), instantiated three times.

Test Plan:
- Reset at 12:34:56, then release with i_btn_mode held high -> outputs 00:00:00, o_state=0, o_blank=0; no press registered until the button is released and pressed again.
- Preload 23:59:59 via set mode, return to RUN, pulse i_tick -> next cycle 00:00:00.
- RUN, mode press -> o_state=1. Five inc presses -> o_sec=5 with o_min unchanged. Sel twice -> o_state=3. Inc from hour=23 -> hour=0 with no other field changed.
- BLINK_HALF=4, SET_MIN idle -> o_blank toggles 6'b000000/6'b001100 every 4 cycles. An inc press clears the phase -> o_blank=0 for the next 4 cycles.
- Mode and inc rising in the same cycle while in RUN -> o_state=1, o_sec unchanged. i_tick pulses in SET_SEC -> time frozen.
- ALARM_EN, alarm 07:30 on, run from 07:29:58 -> o_alarm high the cycle after 07:30:00. A sel press clears it; otherwise it falls after 60 ticks.

Source files
------------

// File: rtl/hms_clock_pkg.sv
// rtl/hms_clock_pkg.sv - state encoding, field limits and blink masks for the time-of-day controller
package hms_clock_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_SET_SEC  = 2'd1,
        ST_SET_MIN  = 2'd2,
        ST_SET_HOUR = 2'd3
    } state_e;

    localparam logic [5:0] SEC_MAX  = 6'd59;
    localparam logic [5:0] MIN_MAX  = 6'd59;
    localparam logic [4:0] HOUR_MAX = 5'd23;

    localparam logic [5:0] BLANK_SEC  = 6'b000011;
    localparam logic [5:0] BLANK_MIN  = 6'b001100;
    localparam logic [5:0] BLANK_HOUR = 6'b110000;

    localparam int ALARM_TICKS = 60;

    // Values at or beyond the limit (including unreachable ones) roll to zero
    function automatic logic [5:0] wrap_inc6(input logic [5:0] v, input logic [5:0] lim);
        return (v >= lim) ? 6'd0 : v + 6'd1;
    endfunction

    function automatic logic [4:0] wrap_inc5(input logic [4:0] v, input logic [4:0] lim);
        return (v >= lim) ? 5'd0 : v + 5'd1;
    endfunction

    function automatic logic [5:0] blank_mask(input state_e st);
        case (st)
            ST_SET_SEC:  return BLANK_SEC;
            ST_SET_MIN:  return BLANK_MIN;
            ST_SET_HOUR: return BLANK_HOUR;
            default:     return 6'd0;
        endcase
    endfunction

endpackage

// File: rtl/hms_clock_ctrl_btn_edge.sv
// rtl/hms_clock_ctrl_btn_edge.sv - registered rising-edge press detector for one debounced button
module btn_edge (
    input  logic clk,
    input  logic rst,
    input  logic i_btn,
    output logic o_press
);

    logic lvl_q, lvl_d;
    logic prev_q, prev_d;
    logic armed_q, armed_d;

    // armed stays low until the button is seen released, so a level held through reset never counts
    always_comb begin
        lvl_d   = i_btn;
        prev_d  = lvl_q;
        armed_d = armed_q | ~i_btn;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lvl_q   <= 1'b0;
            prev_q  <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            lvl_q   <= lvl_d;
            prev_q  <= prev_d;
            armed_q <= armed_d;
        end
    end

    assign o_press = lvl_q & ~prev_q & armed_q;

endmodule

// File: rtl/hms_clock_ctrl.sv
// rtl/hms_clock_ctrl.sv - hh:mm:ss counter with button set mode and blink mask; alarm under HMS_CLOCK_CTRL_ALARM_EN
module hms_clock_ctrl
    import hms_clock_pkg::*;
#(
    parameter int BLINK_HALF = 25000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_tick,
    input  logic       i_btn_mode,
    input  logic       i_btn_sel,
    input  logic       i_btn_inc,
`ifdef HMS_CLOCK_CTRL_ALARM_EN
    input  logic       i_alarm_on,
    input  logic [4:0] i_alarm_hour,
    input  logic [5:0] i_alarm_min,
    output logic       o_alarm,
`endif
    output logic [5:0] o_sec,
    output logic [5:0] o_min,
    output logic [4:0] o_hour,
    output logic [1:0] o_state,
    output logic [5:0] o_blank
);

    localparam int CW = $clog2(BLINK_HALF);

    logic press_mode, press_sel, press_inc;

    btn_edge u_mode (.clk(clk), .rst(rst), .i_btn(i_btn_mode), .o_press(press_mode));
    btn_edge u_sel  (.clk(clk), .rst(rst), .i_btn(i_btn_sel),  .o_press(press_sel));
    btn_edge u_inc  (.clk(clk), .rst(rst), .i_btn(i_btn_inc),  .o_press(press_inc));

    state_e        state_q, state_d;
    logic [5:0]    sec_q, sec_d;
    logic [5:0]    min_q, min_d;
    logic [4:0]    hour_q, hour_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          phase_q, phase_d;
    logic [5:0]    blank_q, blank_d;
    logic          blink_clr;
    logic          tick_run;

    always_comb begin
        state_d   = state_q;
        sec_d     = sec_q;
        min_d     = min_q;
        hour_d    = hour_q;
        cnt_d     = cnt_q;
        phase_d   = phase_q;
        blink_clr = 1'b0;
        tick_run  = (state_q == ST_RUN) && i_tick;

        if (tick_run) begin
            sec_d = wrap_inc6(sec_q, SEC_MAX);
            if (sec_q >= SEC_MAX) begin
                min_d = wrap_inc6(min_q, MIN_MAX);
                if (min_q >= MIN_MAX) begin
                    hour_d = wrap_inc5(hour_q, HOUR_MAX);
                end
            end
        end

        // mode outranks sel, sel outranks inc
        if (press_mode) begin
            state_d   = (state_q == ST_RUN) ? ST_SET_SEC : ST_RUN;
            blink_clr = 1'b1;
        end else if (press_sel) begin
            case (state_q)
                ST_SET_SEC:  state_d = ST_SET_MIN;
                ST_SET_MIN:  state_d = ST_SET_HOUR;
                ST_SET_HOUR: state_d = ST_SET_SEC;
                default:     state_d = ST_RUN;
            endcase
            blink_clr = 1'b1;
        end else if (press_inc) begin
            case (state_q)
                ST_SET_SEC:  sec_d  = wrap_inc6(sec_q, SEC_MAX);
                ST_SET_MIN:  min_d  = wrap_inc6(min_q, MIN_MAX);
                ST_SET_HOUR: hour_d = wrap_inc5(hour_q, HOUR_MAX);
                default:     ;
            endcase
            blink_clr = 1'b1;
        end

        if ((state_d == ST_RUN) || blink_clr) begin
            cnt_d   = '0;
            phase_d = 1'b0;
        end else if (cnt_q == CW'(BLINK_HALF - 1)) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end

        blank_d = phase_d ? blank_mask(state_d) : 6'd0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
            sec_q   <= 6'd0;
            min_q   <= 6'd0;
            hour_q  <= 5'd0;
            cnt_q   <= '0;
            phase_q <= 1'b0;
            blank_q <= 6'd0;
        end else begin
            state_q <= state_d;
            sec_q   <= sec_d;
            min_q   <= min_d;
            hour_q  <= hour_d;
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            blank_q <= blank_d;
        end
    end

`ifdef HMS_CLOCK_CTRL_ALARM_EN
    logic       alarm_q, alarm_d;
    logic [5:0] acnt_q, acnt_d;
    logic       alarm_hit;

    always_comb begin
        alarm_d   = alarm_q;
        acnt_d    = acnt_q;
        alarm_hit = tick_run && i_alarm_on && (hour_d == i_alarm_hour) &&
                    (min_d == i_alarm_min) && (sec_d == 6'd0);
        if (press_mode || press_sel || press_inc || !i_alarm_on || (state_d != ST_RUN)) begin
            alarm_d = 1'b0;
        end else if (alarm_hit) begin
            alarm_d = 1'b1;
            acnt_d  = 6'd0;
        end else if (alarm_q && tick_run) begin
            if (acnt_q == 6'(ALARM_TICKS - 1)) begin
                alarm_d = 1'b0;
            end else begin
                acnt_d = acnt_q + 6'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alarm_q <= 1'b0;
            acnt_q  <= 6'd0;
        end else begin
            alarm_q <= alarm_d;
            acnt_q  <= acnt_d;
        end
    end

    assign o_alarm = alarm_q;
`endif

    assign o_sec   = sec_q;
    assign o_min   = min_q;
    assign o_hour  = hour_q;
    assign o_state = state_q;
    assign o_blank = blank_q;

endmodule
